// File: rtl/lsu_ctrl_if.sv
// Bundle of the execute-side request, writeback-side response and data-RAM
// control signals of the load/store control stage.
// slave  : the lsu_ctrl view.
// master : the surrounding environment view (EX, WB and the memory block).
interface lsu_ctrl_if #(
    parameter int AW = 11
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [1:0]    rsp_cause;

    logic          mem_stall;
    logic [2:0]    mem_op;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_cause,
        output mem_stall, mem_op, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_cause,
        input  mem_stall, mem_op, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the data-RAM block.
// One request in flight at a time: IDLE -> ISSUE -> (WAIT) -> RESP.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned halfword/word
// accesses fault with cause 01; when undefined the address is forced to
// natural alignment and the access proceeds.
module lsu_ctrl #(
    parameter logic [31:0] DMEM_BASE = 32'h0000_0000,
    parameter int          DMEM_AW   = 11
) (
    input  logic      clk,
    input  logic      nrst,
    lsu_ctrl_if.slave bus
);
    // op_code encodings understood by the memory block
    localparam logic [2:0] LoadByte      = 3'd0;
    localparam logic [2:0] LoadHalfWord  = 3'd1;
    localparam logic [2:0] LoadWord      = 3'd2;
    localparam logic [2:0] StoreByte     = 3'd4;
    localparam logic [2:0] StoreHalfWord = 3'd5;
    localparam logic [2:0] StoreWord     = 3'd6;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_ALIGN = 2'b01;
    localparam logic [1:0] C_RANGE = 2'b10;
    localparam logic [1:0] C_ILL   = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                rdy_q, rdy_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic                mem_stall_q, mem_stall_d;
    logic [2:0]          mem_op_q, mem_op_d;
    logic [DMEM_AW-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [1:0]          rsp_cause_q, rsp_cause_d;

    logic [31:0]         off;
    logic [DMEM_AW-1:0]  aoff;
    logic                ill, oor, mis, mis_fault;

    function automatic logic [2:0] map_op(input logic we, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return we ? StoreByte     : LoadByte;
            2'b01:   return we ? StoreHalfWord : LoadHalfWord;
            default: return we ? StoreWord     : LoadWord;
        endcase
    endfunction

    // request checks; wrap-around makes addresses below the base out of range
    always_comb begin
        off  = bus.req_addr - DMEM_BASE;
        ill  = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
               (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
        oor  = |off[31:DMEM_AW];
        // base is 2 KB aligned, so offset low bits equal address low bits
        mis  = ((bus.req_funct3[1:0] == 2'b01) && off[0]) ||
               ((bus.req_funct3[1:0] == 2'b10) && (off[1:0] != 2'b00));
        // natural alignment is harmless for trapped requests, which never issue
        aoff = off[DMEM_AW-1:0];
        if (bus.req_funct3[1:0] == 2'b01) aoff[0]   = 1'b0;
        if (bus.req_funct3[1:0] == 2'b10) aoff[1:0] = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_fault = mis;
`else
        mis_fault = 1'b0;
`endif
    end

    // next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        mem_stall_d = 1'b1;
        mem_op_d    = LoadWord;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_cause_d = rsp_cause_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && rdy_q) begin
                    we_d        = bus.req_we;
                    f3_d        = bus.req_funct3;
                    mem_wdata_d = bus.req_wdata;
                    if (ill || oor || mis_fault) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_cause_d = ill ? C_ILL : (oor ? C_RANGE : C_ALIGN);
                    end else begin
                        state_d     = ISSUE;
                        mem_stall_d = 1'b0;
                        mem_op_d    = map_op(bus.req_we, bus.req_funct3);
                        mem_addr_d  = aoff;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    rsp_cause_d = C_NONE;
                end else begin
                    // memory lane-selects on the live address, so hold it
                    state_d  = WAIT;
                    mem_op_d = mem_op_q;
                end
            end
            WAIT: begin
                state_d     = RESP;
                mem_op_d    = mem_op_q;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_cause_d = C_NONE;
                case (f3_q)
                    3'b100:  rsp_data_d = {24'b0, bus.mem_rdata[7:0]};
                    3'b101:  rsp_data_d = {16'b0, bus.mem_rdata[15:0]};
                    default: rsp_data_d = bus.mem_rdata;
                endcase
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    // state and output registers; reset parks the RAM interface immediately
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            mem_stall_q <= 1'b1;
            mem_op_q    <= LoadWord;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_cause_q <= C_NONE;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            mem_stall_q <= mem_stall_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_cause_q <= rsp_cause_d;
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.mem_stall = mem_stall_q;
    assign bus.mem_op    = mem_op_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_cause = rsp_cause_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed test-plan steps plus random requests, checked
// against a byte-array reference model of the spec rules.
`timescale 1ns/1ps
module tb_lsu_ctrl;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2;
    localparam logic [2:0] OP_SB = 3'd4, OP_SH = 3'd5, OP_SW = 3'd6;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic ram_clr = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    lsu_ctrl_if #(.AW(11)) bus();
    lsu_ctrl #(.DMEM_BASE(BASE), .DMEM_AW(11)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    // behavioural stand-in for the memory block
    logic [7:0] ram     [2048];
    logic [7:0] ref_mem [2048];

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 2048; i++) ram[i] <= init_byte(i);
        end else if (!bus.mem_stall) begin
            case (bus.mem_op)
                OP_SB: ram[bus.mem_addr] <= bus.mem_wdata[7:0];
                OP_SH: begin
                    ram[{bus.mem_addr[10:1], 1'b0}] <= bus.mem_wdata[7:0];
                    ram[{bus.mem_addr[10:1], 1'b1}] <= bus.mem_wdata[15:8];
                end
                OP_SW: for (int i = 0; i < 4; i++)
                    ram[{bus.mem_addr[10:2], 2'(i)}] <= bus.mem_wdata[8*i +: 8];
                default: ;
            endcase
        end
    end

    always_comb begin
        logic [10:0] a;
        a = bus.mem_addr;
        bus.mem_rdata = '0;
        case (bus.mem_op)
            OP_LB: bus.mem_rdata = {{24{ram[a][7]}}, ram[a]};
            OP_LH: bus.mem_rdata = {{16{ram[{a[10:1], 1'b1}][7]}},
                                    ram[{a[10:1], 1'b1}], ram[{a[10:1], 1'b0}]};
            OP_LW: bus.mem_rdata = {ram[{a[10:2], 2'd3}], ram[{a[10:2], 2'd2}],
                                    ram[{a[10:2], 2'd1}], ram[{a[10:2], 2'd0}]};
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // reference: plain rules on a byte array
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [1:0] cause,
                         output logic [31:0] data, output logic [10:0] aaddr);
        logic [31:0] off;
        int size;
        logic [31:0] val;
        off   = addr - BASE;
        size  = 1 << f3[1:0];
        err   = 1'b1;
        data  = 32'd0;
        aaddr = 11'(off - (off % size));
        if (f3 == 3 || f3 == 6 || f3 == 7 || (we && f3 >= 4)) cause = 2'd3;
        else if (off >= 2048) cause = 2'd2;
`ifdef LSU_MISALIGN_TRAP_EN
        else if (off % size != 0) cause = 2'd1;
`endif
        else begin
            err   = 1'b0;
            cause = 2'd0;
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[int'(aaddr) + i] = wd[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val = val + (32'(ref_mem[int'(aaddr) + i]) << (8*i));
                if (f3 == 3'b000 && val >= 128)   val = val + 32'hFFFF_FF00;
                if (f3 == 3'b001 && val >= 32768) val = val + 32'hFFFF_0000;
                data = val;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold,
                         output logic [31:0] got);
        logic e_err;
        logic [1:0] e_cause;
        logic [31:0] e_data;
        logic [10:0] e_addr;
        int e_lat, lat;
        logic low_seen;
        model(we, f3, addr, wd, e_err, e_cause, e_data, e_addr);
        e_lat = e_err ? 1 : (we ? 2 : 3);
        @(negedge clk);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.rsp_ready  = (hold == 0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        low_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.mem_stall) begin
                low_seen = 1'b1;
                check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(e_addr));
                check({tag, ".mem_wdata"}, bus.mem_wdata, wd);
            end
        end while (!bus.rsp_valid && lat < 10);
        got = bus.rsp_data;
        check({tag, ".latency"}, 32'(lat), 32'(e_lat));
        check({tag, ".rsp_data"}, bus.rsp_data, e_data);
        check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(e_err));
        check({tag, ".rsp_cause"}, 32'(bus.rsp_cause), 32'(e_cause));
        check({tag, ".ram_access"}, 32'(low_seen), 32'(!e_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, ".hold_data"}, bus.rsp_data, e_data);
            check({tag, ".hold_cause"}, {29'd0, bus.rsp_err, bus.rsp_cause}, {29'd0, e_err, e_cause});
            check({tag, ".hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] got;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_byte(i);
        repeat (2) @(posedge clk);
        ram_clr = 1'b0;
        #1;
        check("rst.req_ready", 32'(bus.req_ready), 32'd0);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rsp_data", bus.rsp_data, 32'd0);
        check("rst.rsp_err", {30'd0, bus.rsp_err, 1'b0} | 32'(bus.rsp_cause), 32'd0);
        check("rst.mem_stall", 32'(bus.mem_stall), 32'd1);
        check("rst.mem_op", 32'(bus.mem_op), 32'(OP_LW));
        check("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst.mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk);
        #1 check("idle.req_ready", 32'(bus.req_ready), 32'd1);

        do_op("sw40", 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 0, got);
        do_op("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 0, got);
        check("lw40.const", got, 32'hDEADBEEF);
        check("idle.mem_op", 32'(bus.mem_op), 32'(OP_LW));
        do_op("sb41", 1'b1, 3'b000, 32'h41, 32'h80, 0, got);
        do_op("lb41", 1'b0, 3'b000, 32'h41, 32'h0, 0, got);
        check("lb41.const", got, 32'hFFFFFF80);
        do_op("lbu41", 1'b0, 3'b100, 32'h41, 32'h0, 0, got);
        check("lbu41.const", got, 32'h00000080);
        do_op("sh42", 1'b1, 3'b001, 32'h42, 32'h8001, 0, got);
        do_op("lhu42", 1'b0, 3'b101, 32'h42, 32'h0, 0, got);
        check("lhu42.const", got, 32'h00008001);
        do_op("sw7fc", 1'b1, 3'b010, 32'h7FC, 32'h12345678, 0, got);
        do_op("sw400", 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 0, got);
        do_op("lw7fc", 1'b0, 3'b010, 32'h7FC, 32'h0, 0, got);
        check("lw7fc.const", got, 32'h12345678);
        do_op("lw400", 1'b0, 3'b010, 32'h400, 32'h0, 0, got);
        check("lw400.const", got, 32'hCAFEF00D);
        do_op("lw800", 1'b0, 3'b010, 32'h800, 32'h0, 0, got);
        do_op("lwwrap", 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 0, got);
        do_op("lw42", 1'b0, 3'b010, 32'h42, 32'h0, 0, got);
`ifndef LSU_MISALIGN_TRAP_EN
        check("lw42.const", got, 32'h800180EF);
`endif
        do_op("st_f3_100", 1'b1, 3'b100, 32'h40, 32'h11111111, 5, got);
        do_op("lw40.after_ill", 1'b0, 3'b010, 32'h40, 32'h0, 0, got);
        check("lw40.unchanged", got, 32'h800180EF);

        // reset in the middle of a load's WAIT cycle
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h40;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        check("mid_rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst.mem_stall", 32'(bus.mem_stall), 32'd1);
        check("mid_rst.req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk);
        do_op("lw40.after_rst", 1'b0, 3'b010, 32'h40, 32'h0, 0, got);
        check("lw40.after_rst.const", got, 32'h800180EF);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h7FF);
            do_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  a, $urandom, 0, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
